// File: rtl/vsim_msg_serializer_if.sv
// Message-in / beat-out bus of the DPI sender serializer.
// The slave modport is the serializer's view; the master modport is its environment.
interface vsim_msg_serializer_if #(
  parameter int width     = 32,
  parameter int MAX_BEATS = 16
);
  localparam int LEN_W = $clog2(MAX_BEATS + 1);

  logic                       msg__ENA;
  logic                       msg__RDY;
  logic [MAX_BEATS*width-1:0] msg_data;
  logic [LEN_W-1:0]           msg_len;
  logic [15:0]                msg_id;
  logic                       beat__ENA;
  logic                       beat__RDY;
  logic [width-1:0]           beat_v;
  logic                       beat_last;

  modport slave (
    input  msg__ENA, msg_data, msg_len, msg_id, beat__RDY,
    output msg__RDY, beat__ENA, beat_v, beat_last
  );

  modport master (
    output msg__ENA, msg_data, msg_len, msg_id, beat__RDY,
    input  msg__RDY, beat__ENA, beat_v, beat_last
  );
endinterface

// File: rtl/vsim_msg_serializer.sv
// Serializer: takes one whole message per handshake and streams it out as
// width-bit beats, LSB word first, with a last flag. One message of buffering;
// the next message loads in the same cycle the last beat leaves, so no bubble.
// Optional feature macro: VSIM_SER_HEADER_EN -- prepend a header beat
// {id[15:0], clamped_len[15:0]}; zero-length messages then emit the header alone.
module vsim_msg_serializer #(
  parameter int width     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  vsim_msg_serializer_if.slave        bus,
  output logic [7:0]                  drop_cnt
);
  localparam int LEN_W = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] HDR  = 2'd2;

  logic [1:0]                 state_r;
  logic [MAX_BEATS*width-1:0] data_r;
  logic [LEN_W-1:0]           len_r;
  logic [LEN_W-1:0]           idx_r;
  logic                       beat_ena_r;
  logic                       beat_last_r;
  logic [width-1:0]           beat_v_r;
  logic [7:0]                 drop_cnt_r;

  logic                       xfer_s;
  logic                       last_xfer_s;
  logic                       rdy_s;
  logic                       accept_s;
  logic [LEN_W-1:0]           len_in_s;
  logic [LEN_W-1:0]           idx_nxt_s;
  logic [width-1:0]           word_nxt_s;

`ifdef VSIM_SER_HEADER_EN
  // Header word: id in the upper half, clamped length in the lower half.
  function automatic logic [width-1:0] hdr_word(input logic [15:0] id,
                                                input logic [LEN_W-1:0] len);
    logic [31:0] h;
    h = {id, 16'(len)};
    return width'(h);
  endfunction
`endif

  // Handshake decode; ready is open in IDLE or while the final beat is leaving.
  always_comb begin
    xfer_s      = beat_ena_r && bus.beat__RDY;
    last_xfer_s = xfer_s && beat_last_r;
    rdy_s       = nRST && ((state_r == IDLE) || last_xfer_s);
    accept_s    = bus.msg__ENA && rdy_s;
    if (bus.msg_len > LEN_W'(MAX_BEATS)) begin
      len_in_s = LEN_W'(MAX_BEATS);
    end else begin
      len_in_s = bus.msg_len;
    end
  end

  // Select the word that follows the one currently presented.
  always_comb begin
    idx_nxt_s  = idx_r + LEN_W'(1);
    word_nxt_s = {width{1'b0}};
    for (int k = 0; k < MAX_BEATS; k++) begin
      if (idx_nxt_s == LEN_W'(k)) begin
        word_nxt_s = data_r[k*width +: width];
      end else begin
        word_nxt_s = word_nxt_s;
      end
    end
  end

  // Message capture, beat sequencing and registered beat outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      data_r      <= {(MAX_BEATS*width){1'b0}};
      len_r       <= {LEN_W{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      beat_ena_r  <= 1'b0;
      beat_v_r    <= {width{1'b0}};
      beat_last_r <= 1'b0;
    end else if (accept_s) begin
      data_r <= bus.msg_data;
      len_r  <= len_in_s;
      idx_r  <= {LEN_W{1'b0}};
`ifdef VSIM_SER_HEADER_EN
      state_r     <= HDR;
      beat_ena_r  <= 1'b1;
      beat_v_r    <= hdr_word(bus.msg_id, len_in_s);
      beat_last_r <= (len_in_s == LEN_W'(0));
`else
      if (len_in_s == LEN_W'(0)) begin
        // Nothing to send: discard and stay idle.
        state_r     <= IDLE;
        beat_ena_r  <= 1'b0;
        beat_v_r    <= {width{1'b0}};
        beat_last_r <= 1'b0;
      end else begin
        state_r     <= DATA;
        beat_ena_r  <= 1'b1;
        beat_v_r    <= bus.msg_data[width-1:0];
        beat_last_r <= (len_in_s == LEN_W'(1));
      end
`endif
    end else if (xfer_s) begin
      case (state_r)
        HDR: begin
          if (beat_last_r) begin
            state_r     <= IDLE;
            beat_ena_r  <= 1'b0;
            beat_v_r    <= {width{1'b0}};
            beat_last_r <= 1'b0;
          end else begin
            state_r     <= DATA;
            idx_r       <= {LEN_W{1'b0}};
            beat_v_r    <= data_r[width-1:0];
            beat_last_r <= (len_r == LEN_W'(1));
          end
        end
        DATA: begin
          if (beat_last_r) begin
            state_r     <= IDLE;
            beat_ena_r  <= 1'b0;
            beat_v_r    <= {width{1'b0}};
            beat_last_r <= 1'b0;
          end else begin
            idx_r       <= idx_nxt_s;
            beat_v_r    <= word_nxt_s;
            beat_last_r <= (idx_nxt_s == (len_r - LEN_W'(1)));
          end
        end
        default: begin
          state_r     <= IDLE;
          beat_ena_r  <= 1'b0;
          beat_v_r    <= {width{1'b0}};
          beat_last_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Saturating count of zero-length messages discarded without any beat.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      drop_cnt_r <= 8'd0;
    end else begin
`ifdef VSIM_SER_HEADER_EN
      drop_cnt_r <= drop_cnt_r;
`else
      if (accept_s && (len_in_s == LEN_W'(0)) && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
`endif
    end
  end

  assign bus.msg__RDY  = rdy_s;
  assign bus.beat__ENA = beat_ena_r;
  assign bus.beat_v    = beat_v_r;
  assign bus.beat_last = beat_last_r;
  assign drop_cnt      = drop_cnt_r;

endmodule
